eq_div_sched: RTL and testbench

- Time-shares a single pipelined divider core (div_gen_0 class, fixed latency) between the I and Q channel-coefficient divisions of the equalizer.
- Accepts one request per subcarrier: I dividend, Q dividend and a common divisor. It issues the I and Q operands to the divider on consecutive cycles, tags every operand in flight, and re-pairs the two quotients into one output beat.
- Sits between the channel-estimate averaging stage and the complex multipliers. It replaces the two parallel dividers with one, at the cost of half the throughput.

---
 rtl/eq_div_sched.sv | 202 ++++++++++++++++++++
 tb/tb_eq_div_sched.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eq_div_sched.sv
// eq_div_sched: shares one fixed-latency pipelined divider between the I and Q
// coefficient divisions of the equalizer. Each accepted request issues its I
// operand and then its Q operand on consecutive cycles. A tag pipe, aligned
// with the divider latency, identifies each returning quotient. The two
// quotients are re-paired into a single result beat.
//
// Handshake: a request transfers on a rising clk edge where req_val and
// req_rdy are both 1. req_rdy is high only in IDLE and is never high while rst
// is asserted. The divider side has no backpressure: div_val/div_num/div_den
// are valid for exactly one cycle per operand, and div_oval must return
// DIV_LAT cycles later. res_val is a one-cycle pulse, and the consumer must
// always accept it.
module eq_div_sched #(
  parameter int NUM_W   = 32,
  parameter int Q_W     = 32,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_val,
  output logic             req_rdy,
  input  logic             req_sop,
  input  logic [NUM_W-1:0] req_num_i,
  input  logic [NUM_W-1:0] req_num_q,
  input  logic [NUM_W-1:0] req_den,
  output logic             div_val,
  output logic [NUM_W-1:0] div_num,
  output logic [NUM_W-1:0] div_den,
  input  logic             div_oval,
  input  logic [Q_W-1:0]   div_quot,
  output logic             res_val,
  output logic             res_sop,
  output logic [Q_W-1:0]   res_i,
  output logic [Q_W-1:0]   res_q,
  output logic             res_dz,
  output logic             err,
  output logic [0:0]       dbg_state
);

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_ISSUE_Q = 1'b1;

  // Tag bit positions: {valid, is_q, sop, dz}
  localparam int TAG_V   = 3;
  localparam int TAG_Q   = 2;
  localparam int TAG_SOP = 1;
  localparam int TAG_DZ  = 0;

  logic [0:0]       r_state;
  logic [NUM_W-1:0] r_num_q;
  logic [NUM_W-1:0] r_den;
  logic             r_sop;
  logic             r_dz;

  logic             r_div_val;
  logic [NUM_W-1:0] r_div_num;
  logic [NUM_W-1:0] r_div_den;
  logic             r_cur_q;
  logic             r_cur_sop;
  logic             r_cur_dz;

  logic [3:0]       r_tag [DIV_LAT];

  logic [Q_W-1:0]   r_held_i;
  logic             r_held_flag;
  logic [1:0]       r_grace;

  logic             r_res_val;
  logic             r_res_sop;
  logic [Q_W-1:0]   r_res_i;
  logic [Q_W-1:0]   r_res_q;
  logic             r_res_dz;
  logic             r_err;

  logic             w_xfer;
  logic [3:0]       w_head;
  logic             w_head_v;
  logic             w_stray_ok;
  logic             w_val_err;

  assign req_rdy   = ~rst & (r_state == S_IDLE);
  assign w_xfer    = req_val & req_rdy;
  assign dbg_state = r_state;

  assign div_val = r_div_val;
  assign div_num = r_div_num;
  assign div_den = r_div_den;

  assign res_val = r_res_val;
  assign res_sop = r_res_sop;
  assign res_i   = r_res_i;
  assign res_q   = r_res_q;
  assign res_dz  = r_res_dz;
  assign err     = r_err;

  assign w_head   = r_tag[DIV_LAT-1];
  assign w_head_v = w_head[TAG_V];
  // A stray quotient arriving with no tag, shortly after reset, belongs to
  // work that was flushed by the reset. It is dropped silently.
  assign w_stray_ok = div_oval & ~w_head_v & (r_grace != 2'd0);
  assign w_val_err  = (div_oval != w_head_v) & ~w_stray_ok;

  // Issue FSM: accept in IDLE and put I on the bus; put Q on the bus next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_num_q   <= '0;
      r_den     <= '0;
      r_sop     <= 1'b0;
      r_dz      <= 1'b0;
      r_div_val <= 1'b0;
      r_div_num <= '0;
      r_div_den <= '0;
      r_cur_q   <= 1'b0;
      r_cur_sop <= 1'b0;
      r_cur_dz  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            r_div_val <= 1'b1;
            r_div_num <= req_num_i;
            r_div_den <= req_den;
            r_cur_q   <= 1'b0;
            r_cur_sop <= req_sop;
            r_cur_dz  <= (req_den == '0);
            r_num_q   <= req_num_q;
            r_den     <= req_den;
            r_sop     <= req_sop;
            r_dz      <= (req_den == '0);
            r_state   <= S_ISSUE_Q;
          end else begin
            r_div_val <= 1'b0;
          end
        end
        default: begin
          r_div_val <= 1'b1;
          r_div_num <= r_num_q;
          r_div_den <= r_den;
          r_cur_q   <= 1'b1;
          r_cur_sop <= r_sop;
          r_cur_dz  <= r_dz;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  // Tag pipe: follows the issued operand, so that its head lines up with div_oval.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DIV_LAT; i++) r_tag[i] <= 4'd0;
    end else begin
      r_tag[0] <= {r_div_val, r_cur_q, r_cur_sop, r_cur_dz};
      for (int i = 1; i < DIV_LAT; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  // Result pairing: hold the I quotient, then emit the pair when Q returns.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_held_i    <= '0;
      r_held_flag <= 1'b0;
      r_grace     <= 2'd2;
      r_res_val   <= 1'b0;
      r_res_sop   <= 1'b0;
      r_res_i     <= '0;
      r_res_q     <= '0;
      r_res_dz    <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_res_val <= 1'b0;
      if (r_grace != 2'd0) r_grace <= r_grace - 2'd1;
      if (w_val_err) r_err <= 1'b1;
      if (w_head_v) begin
        if (!w_head[TAG_Q]) begin
          // I slot: a second I quotient without a Q resyncs onto the newer one.
          if (div_oval) begin
            if (r_held_flag) r_err <= 1'b1;
            r_held_i    <= div_quot;
            r_held_flag <= 1'b1;
          end
        end else begin
          // Q slot closes the pair whether or not it completes cleanly.
          r_held_flag <= 1'b0;
          if (div_oval) begin
            if (!r_held_flag) begin
              r_err <= 1'b1;
            end else begin
              r_res_val <= 1'b1;
              r_res_i   <= r_held_i;
              r_res_q   <= div_quot;
              r_res_sop <= w_head[TAG_SOP];
              r_res_dz  <= w_head[TAG_DZ];
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_eq_div_sched.sv
// Bench for eq_div_sched: a pipelined divider model, a reference model of the
// request/bus/result timing, a compare process that runs every cycle, and
// directed plus randomized stimulus.
module tb_eq_div_sched;

  localparam int L  = 10;
  localparam int NW = 32;
  localparam int QW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          req_val, req_rdy, req_sop;
  logic [NW-1:0] req_num_i, req_num_q, req_den;
  logic          div_val, div_oval;
  logic [NW-1:0] div_num, div_den;
  logic [QW-1:0] div_quot;
  logic          res_val, res_sop, res_dz, err;
  logic [QW-1:0] res_i, res_q;
  logic [0:0]    dbg_state;

  eq_div_sched #(.NUM_W(NW), .Q_W(QW), .DIV_LAT(L)) dut (
    .clk(clk), .rst(rst),
    .req_val(req_val), .req_rdy(req_rdy), .req_sop(req_sop),
    .req_num_i(req_num_i), .req_num_q(req_num_q), .req_den(req_den),
    .div_val(div_val), .div_num(div_num), .div_den(div_den),
    .div_oval(div_oval), .div_quot(div_quot),
    .res_val(res_val), .res_sop(res_sop), .res_i(res_i), .res_q(res_q),
    .res_dz(res_dz), .err(err), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] qfn(input logic [31:0] n, input logic [31:0] d);
    if (d == 32'd0) return 32'hFFFF_FFFF;
    return $signed(n) / $signed(d);
  endfunction

  // ---------------- divider model ----------------
  // An operand on the bus in cycle c returns as div_oval in cycle c+L. The
  // divider is flushed by rst.
  logic        dm_v [L+1];
  logic [31:0] dm_q [L+1];
  bit          drop_next = 1'b0;
  int          stray_cyc = -1;

  initial begin
    div_oval = 1'b0;
    div_quot = '0;
    for (int i = 0; i <= L; i++) begin dm_v[i] = 1'b0; dm_q[i] = '0; end
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int i = 0; i <= L; i++) dm_v[i] = 1'b0;
        div_oval = 1'b0;
      end else begin
        for (int i = L; i > 0; i--) begin dm_v[i] = dm_v[i-1]; dm_q[i] = dm_q[i-1]; end
        dm_v[0] = div_val;
        dm_q[0] = qfn(div_num, div_den);
        if (div_val && drop_next) begin dm_v[0] = 1'b0; drop_next = 1'b0; end
        div_oval = dm_v[L] | (cyc == stray_cyc);
        div_quot = dm_q[L];
      end
    end
  end

  // ---------------- reference model + scoreboard ----------------
  // exp_q entry: {due_cycle[31:0], sop, dz, i_quot[31:0], q_quot[31:0]}
  logic [97:0] exp_q[$];
  int          last_acc = -100;
  logic [31:0] l_i, l_q, l_d;
  bit          acc_prev = 1'b0;
  bit          rst_prev = 1'b0;
  bit          drop_mark = 1'b0;
  int          err_from = 1 << 30;

  initial begin
    forever begin
      bit          m_rdy;
      logic [97:0] e;
      @(negedge clk);
      m_rdy = !rst && !acc_prev;
      chk("req_rdy", req_rdy, m_rdy);
      if (rst) begin
        if (rst_prev)
          chk("reset_outputs_zero",
              |{div_val, div_num, div_den, res_val, res_sop, res_i, res_q, res_dz, err}, 1'b0);
        exp_q.delete();
        acc_prev = 1'b0;
        last_acc = -100;
        err_from = 1 << 30;
      end else begin
        if (cyc == last_acc + 1) begin
          chk("div_val_i", div_val, 1'b1);
          chk("div_num_i", div_num, l_i);
          chk("div_den_i", div_den, l_d);
        end else if (cyc == last_acc + 2) begin
          chk("div_val_q", div_val, 1'b1);
          chk("div_num_q", div_num, l_q);
          chk("div_den_q", div_den, l_d);
        end else begin
          chk("div_val_idle", div_val, 1'b0);
        end
        if (exp_q.size() > 0 && e_due(exp_q[0]) == cyc) begin
          e = exp_q.pop_front();
          chk("res_val", res_val, 1'b1);
          chk("res_sop", res_sop, e[65]);
          chk("res_dz", res_dz, e[64]);
          if (!e[64]) begin
            chk("res_i", res_i, e[63:32]);
            chk("res_q", res_q, e[31:0]);
          end
        end else begin
          chk("res_val_quiet", res_val, 1'b0);
        end
        chk("err", err, cyc >= err_from);
        if (req_val && m_rdy) begin
          last_acc = cyc;
          l_i = req_num_i; l_q = req_num_q; l_d = req_den;
          if (drop_mark) begin
            // The I quotient goes missing: the error shows the cycle after its slot.
            if (err_from > cyc + L + 2) err_from = cyc + L + 2;
            drop_mark = 1'b0;
          end else begin
            exp_q.push_back({32'(cyc + L + 3), req_sop, (req_den == 32'd0),
                             qfn(req_num_i, req_den), qfn(req_num_q, req_den)});
          end
        end
        acc_prev = req_val && m_rdy;
      end
      rst_prev = rst;
    end
  end

  function automatic int e_due(input logic [97:0] e);
    return int'(e[97:66]);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input logic [31:0] ni, input logic [31:0] nq, input logic [31:0] nd,
                      input logic s, input bit drop, output int acc_c);
    int budget;
    req_val = 1'b1; req_num_i = ni; req_num_q = nq; req_den = nd; req_sop = s;
    if (drop) begin drop_next = 1'b1; drop_mark = 1'b1; end
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (!req_rdy && budget < 20);
    chk("accept_within_budget", req_rdy, 1'b1);
    acc_c = cyc;
    @(posedge clk); #1;
    req_val = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_den();
    logic [31:0] d;
    d = 32'($urandom_range(1, 1000));
    if ($urandom_range(0, 1) == 1) d = -d;
    return d;
  endfunction

  function automatic logic [31:0] rand_num();
    logic [31:0] n;
    n = $urandom;
    if (n == 32'h8000_0000) n = 32'd1;
    return n;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int a;
    req_val = 1'b0; req_sop = 1'b0;
    req_num_i = '0; req_num_q = '0; req_den = '0;

    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    chk("lit_rdy_after_reset", req_rdy, 1'b1);
    chk("lit_err_after_reset", err, 1'b0);
    idle(1);

    // Single request with hand-computed results.
    send(32'h0000_2800, 32'hFFFF_EC00, 32'd5, 1'b1, 1'b0, a);
    @(negedge clk);
    chk("lit_i_on_bus", {div_val, div_num}, {1'b1, 32'h0000_2800});
    @(negedge clk);
    chk("lit_q_on_bus", {div_val, div_num}, {1'b1, 32'hFFFF_EC00});
    repeat (11) @(negedge clk);
    chk("lit_res_cycle", cyc - a, 13);
    chk("lit_res_val", res_val, 1'b1);
    chk("lit_res_i", res_i, 32'h0000_0800);
    chk("lit_res_q", res_q, 32'hFFFF_FC00);
    chk("lit_res_sop_dz_err", {res_sop, res_dz, err}, 3'b100);
    idle(5);

    // Eight back-to-back pairs, one of them with a zero divisor.
    for (int p = 0; p < 8; p++)
      send(rand_num(), rand_num(), (p == 3) ? 32'd0 : rand_den(), p == 0, 1'b0, a);
    idle(L + 8);

    // A dropped I quotient: error goes sticky, and later pairs still pair up.
    send(rand_num(), rand_num(), rand_den(), 1'b0, 1'b1, a);
    idle(2);
    for (int p = 0; p < 3; p++) begin
      send(rand_num(), rand_num(), rand_den(), 1'b0, 1'b0, a);
      idle(1);
    end
    idle(L + 8);
    chk("lit_err_sticky", err, 1'b1);
    do_reset(2);
    @(negedge clk);
    chk("lit_err_cleared", err, 1'b0);
    idle(1);

    // Reset pulsed three cycles after a transfer; the request must vanish.
    send(rand_num(), rand_num(), rand_den(), 1'b1, 1'b0, a);
    idle(2);
    do_reset(2);
    stray_cyc = cyc + 1;
    idle(L + 10);
    chk("lit_no_err_after_flush", err, 1'b0);

    // A stray quotient well clear of reset is an error.
    stray_cyc = cyc + 3;
    err_from  = stray_cyc + 1;
    idle(6);
    chk("lit_err_stray", err, 1'b1);
    do_reset(2);
    idle(2);

    // Randomized gapped traffic.
    for (int n = 0; n < 200; n++) begin
      int gap;
      logic [31:0] d;
      gap = $urandom_range(1, 5);
      d = ($urandom_range(0, 7) == 0) ? 32'd0 : rand_den();
      send(rand_num(), rand_num(), d, $urandom_range(0, 1) == 1, 1'b0, a);
      if (gap > 1) idle(gap - 1);
    end
    idle(L + 10);
    chk("exp_q_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog");
  end

endmodule
